// File: rtl/timer_peripheral_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, TCON bit positions, default base.
// No logic of its own; constants and types only.
// Not applicable: holds no datapath.
package timer_peripheral_pkg;

    localparam logic [31:0] TIMER_BASE_DEFAULT = 32'h4000_0000;

    // Byte offsets of the word registers inside the window
    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_000C;

    // TCON bit positions
    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_TH,
        REG_TL,
        REG_TCON,
        REG_SYSTICK
    } reg_sel_t;

endpackage

// File: rtl/timer_peripheral.sv
// Reloading 32-bit timer with level interrupt plus free-running SYSTICK, on a simple CPU bus.
// Reads are combinational (0 cycles); writes land on the next rising edge.
// No backpressure: every access completes in its own cycle.
module timer_peripheral
    import timer_peripheral_pkg::*;
#(
    parameter logic [31:0] TIMER_BASE = TIMER_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [31:0] ADDR_TH      = TIMER_BASE + OFF_TH;
    localparam logic [31:0] ADDR_TL      = TIMER_BASE + OFF_TL;
    localparam logic [31:0] ADDR_TCON    = TIMER_BASE + OFF_TCON;
    localparam logic [31:0] ADDR_SYSTICK = TIMER_BASE + OFF_SYSTICK;

    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] systick;
    logic        tcon_en;
    logic        tcon_ie;
    logic        tcon_is;

    reg_sel_t    sel;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        ovf;
    logic [31:0] tcon_word;

    // Exact-match address decode; anything else is unmapped
    always_comb begin
        sel = REG_NONE;
        if (addr == ADDR_TH)           sel = REG_TH;
        else if (addr == ADDR_TL)      sel = REG_TL;
        else if (addr == ADDR_TCON)    sel = REG_TCON;
        else if (addr == ADDR_SYSTICK) sel = REG_SYSTICK;
    end

    // Write strobes per register and the overflow condition on this edge
    always_comb begin
        wr_th   = wr && (sel == REG_TH);
        wr_tl   = wr && (sel == REG_TL);
        wr_tcon = wr && (sel == REG_TCON);
        ovf     = tcon_en && (tl == 32'hFFFF_FFFF);
    end

    // Reload register: only software changes it; reload uses the pre-write value
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      th <= '0;
        else if (wr_th) th <= wdata;
    end

    // Count register: software write beats reload, reload beats increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        tl <= '0;
        else if (wr_tl)   tl <= wdata;
        else if (ovf)     tl <= th;
        else if (tcon_en) tl <= tl + 32'd1;
    end

    // Control/status: an overflow with IE set forces IS high even against a clearing write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcon_en <= 1'b0;
            tcon_ie <= 1'b0;
            tcon_is <= 1'b0;
        end else if (wr_tcon) begin
            tcon_en <= wdata[TCON_EN];
            tcon_ie <= wdata[TCON_IE];
            tcon_is <= wdata[TCON_IS] | (ovf & tcon_ie);
        end else if (ovf && tcon_ie) begin
            tcon_is <= 1'b1;
        end
    end

    // Free-running tick counter, read-only from the bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) systick <= '0;
        else       systick <= systick + 32'd1;
    end

    // Read mux and interrupt level, both purely from current register state
    always_comb begin
        tcon_word = {29'd0, tcon_is, tcon_ie, tcon_en};
        rdata     = '0;
        if (rd) begin
            case (sel)
                REG_TH:      rdata = th;
                REG_TL:      rdata = tl;
                REG_TCON:    rdata = tcon_word;
                REG_SYSTICK: rdata = systick;
                default:     rdata = '0;
            endcase
        end
        irq = tcon_ie & tcon_is;
    end

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed bench for timer_peripheral: vector table for register access, hand sequences for timing cases.
// Inputs change 1 ns after a rising edge; outputs are sampled before the next edge.
// DUT never stalls, so no flow control is modelled.
module tb_timer_peripheral;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_SYS  = 32'h4000_000C;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks;
    int errors;

    typedef struct {
        logic        do_wr;
        logic        do_rd;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[17];

    timer_peripheral #(.TIMER_BASE(32'h4000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        wr    = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        rd   = 1'b1;
        #1;
        chk(name, rdata, exp);
        rd   = 1'b0;
    endtask

    task automatic irq_chk(input string name, input logic exp);
        chk(name, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        addr   = '0;
        rd     = 1'b0;
        wr     = 1'b0;
        wdata  = '0;

        //                 wr    rd    addr                 wdata          rdata          irq
        vecs[0]  = '{1'b1, 1'b0, A_TH,               32'hA5A5_5A5A, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 1'b1, A_TH,               32'h0,         32'hA5A5_5A5A, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, A_TL,               32'h0000_1234, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 1'b1, A_TL,               32'h0,         32'h0000_1234, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, A_TCON,             32'hFFFF_FFF8, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 1'b1, A_TCON,             32'h0,         32'h0,         1'b0};
        vecs[6]  = '{1'b1, 1'b0, A_TCON,             32'h0000_0004, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 1'b1, A_TCON,             32'h0,         32'h0000_0004, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, A_TCON,             32'h0000_0006, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 1'b1, A_TCON,             32'h0,         32'h0000_0006, 1'b1};
        vecs[10] = '{1'b1, 1'b1, A_TCON,             32'h0000_0002, 32'h0000_0006, 1'b1};
        vecs[11] = '{1'b0, 1'b1, A_TCON,             32'h0,         32'h0000_0002, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h4000_0010,      32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h4000_0010,      32'h0,         32'h0,         1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'h4000_0001,      32'h0,         32'h0,         1'b0};
        vecs[15] = '{1'b0, 1'b1, A_TH,               32'h0,         32'hA5A5_5A5A, 1'b0};
        vecs[16] = '{1'b0, 1'b1, A_TL,               32'h0,         32'h0000_1234, 1'b0};

        // Reset state, both while asserted and just after release
        tick(1);
        rd_chk("rst_th",   A_TH,   32'h0);
        rd_chk("rst_tl",   A_TL,   32'h0);
        rd_chk("rst_tcon", A_TCON, 32'h0);
        rd_chk("rst_sys",  A_SYS,  32'h0);
        irq_chk("rst_irq", 1'b0);
        tick(1);
        reset = 1'b0;
        rd_chk("rel_th",   A_TH,   32'h0);
        rd_chk("rel_tl",   A_TL,   32'h0);
        rd_chk("rel_tcon", A_TCON, 32'h0);
        irq_chk("rel_irq", 1'b0);

        // SYSTICK counts edges since release; writes to it are dropped
        tick(100);
        rd_chk("sys_100", A_SYS, 32'd100);
        wr_reg(A_SYS, 32'h0);
        rd_chk("sys_wr_ignored", A_SYS, 32'd101);

        // Register access table, one clock per vector, timer stopped
        foreach (vecs[i]) begin
            addr  = vecs[i].a;
            wdata = vecs[i].d;
            wr    = vecs[i].do_wr;
            rd    = vecs[i].do_rd;
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            @(posedge clk);
            #1;
            wr = 1'b0;
            rd = 1'b0;
        end

        // Reload: TL runs FFFF_FFFE -> FFFF_FFFF -> TH, irq rises with the reload
        wr_reg(A_TH, 32'hFFFF_FFF0);
        wr_reg(A_TL, 32'hFFFF_FFFE);
        wr_reg(A_TCON, 32'h3);
        rd_chk("rl_tl0", A_TL, 32'hFFFF_FFFE);
        tick(1);
        rd_chk("rl_tl1", A_TL, 32'hFFFF_FFFF);
        irq_chk("rl_irq_before", 1'b0);
        tick(1);
        rd_chk("rl_tl2", A_TL, 32'hFFFF_FFF0);
        irq_chk("rl_irq_after", 1'b1);
        rd_chk("rl_tcon", A_TCON, 32'h7);

        // Clear IS, then the next overflow 16 edges after the first one sets it again
        wr_reg(A_TCON, 32'h3);
        irq_chk("clr_irq", 1'b0);
        rd_chk("clr_tl", A_TL, 32'hFFFF_FFF1);
        tick(14);
        rd_chk("clr_tl_top", A_TL, 32'hFFFF_FFFF);
        irq_chk("clr_irq_top", 1'b0);
        tick(1);
        rd_chk("clr_tl_rl", A_TL, 32'hFFFF_FFF0);
        irq_chk("clr_irq_again", 1'b1);

        // Masked: overflow with IE=0 reloads but leaves IS clear
        wr_reg(A_TCON, 32'h1);
        irq_chk("msk_irq0", 1'b0);
        tick(15);
        rd_chk("msk_tl", A_TL, 32'hFFFF_FFF0);
        rd_chk("msk_tcon", A_TCON, 32'h1);
        irq_chk("msk_irq", 1'b0);

        // TL write on the overflow edge: write wins, IS still set
        wr_reg(A_TCON, 32'h0);
        wr_reg(A_TL, 32'hFFFF_FFFF);
        wr_reg(A_TCON, 32'h3);
        wr_reg(A_TL, 32'h5);
        rd_chk("col_tl", A_TL, 32'h5);
        rd_chk("col_tl_tcon", A_TCON, 32'h7);
        irq_chk("col_tl_irq", 1'b1);

        // TH write on the overflow edge: TL gets the old TH
        wr_reg(A_TCON, 32'h0);
        wr_reg(A_TL, 32'hFFFF_FFFF);
        wr_reg(A_TCON, 32'h3);
        wr_reg(A_TH, 32'h0000_1234);
        rd_chk("col_th_tl", A_TL, 32'hFFFF_FFF0);
        rd_chk("col_th_th", A_TH, 32'h0000_1234);
        irq_chk("col_th_irq", 1'b1);

        // TCON write clearing IS on the overflow edge: overflow wins
        wr_reg(A_TCON, 32'h0);
        wr_reg(A_TL, 32'hFFFF_FFFF);
        wr_reg(A_TCON, 32'h3);
        wr_reg(A_TCON, 32'h3);
        rd_chk("col_tcon", A_TCON, 32'h7);
        rd_chk("col_tcon_tl", A_TL, 32'h0000_1234);
        irq_chk("col_tcon_irq", 1'b1);

        // Reset in the middle of a cycle while counting with IS pending
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        irq_chk("mid_rst_irq", 1'b0);
        rd_chk("mid_rst_tl", A_TL, 32'h0);
        rd_chk("mid_rst_tcon", A_TCON, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(3);
        rd_chk("post_rst_tl", A_TL, 32'h0);
        rd_chk("post_rst_tcon", A_TCON, 32'h0);
        rd_chk("post_rst_sys", A_SYS, 32'd3);
        irq_chk("post_rst_irq", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
